// File: rtl/game_controller.sv
// game_controller: sequences one round of the typing game.
// Takes decoded key events and per-frame ticks, and produces the target letter,
// the score, the countdown and the game state for the drawing/control logic.
// Everything runs on pclk. Reset is asynchronous and active-high.
// Optional build macro: STREAK_BONUS_EN. When it is defined, the block counts
// consecutive hits, awards a bonus point during a streak and adds a streak output.
module game_controller #(
    parameter int          FRAMES_PER_SEC = 60,
    parameter int          ROUND_SECONDS  = 60,
    parameter logic [4:0]  START_CODE     = 5'd27,
    parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic [4:0] key_code,
    input  logic       key_valid,
    input  logic       frame_tick,
    output logic [4:0] target_code,
    output logic [7:0] score,
    output logic [7:0] time_left,
    output logic [1:0] game_state,
    output logic       hit,
    output logic       miss,
    output logic       game_over
`ifdef STREAK_BONUS_EN
    ,
    output logic [2:0] streak
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2,
        S_OVER = 2'd3
    } state_t;

    localparam int               FC_W    = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FRAMES_PER_SEC - 1);
    localparam logic [7:0]       ROUND_LEN = 8'(ROUND_SECONDS);

    state_t          state_reg;
    logic [4:0]      target_reg;
    logic [7:0]      score_reg;
    logic [7:0]      time_reg;
    logic [FC_W-1:0] frame_cnt_reg;
    logic            hit_reg;
    logic            miss_reg;
    logic            game_over_reg;
    logic [7:0]      lfsr_reg;
    logic [7:0]      lfsr_next;
    logic            lfsr_fb;
`ifdef STREAK_BONUS_EN
    logic [2:0]      streak_reg;
`endif

    // ------------------------------------------------------------------
    // Letter source: 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
    // It runs every cycle regardless of state so the letter sequence depends
    // on when the player presses keys.
    // ------------------------------------------------------------------
    assign lfsr_fb      = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
    assign lfsr_next[0] = lfsr_fb;

    genvar gi;
    generate
        for (gi = 1; gi < 8; gi++) begin : g_lfsr_shift
            assign lfsr_next[gi] = lfsr_reg[gi-1];
        end
    endgenerate

    // Advance the LFSR on every clock; only reset returns it to the seed
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-letter function: fold the low five LFSR bits into 1..26 and bump
    // by one (26 wraps to 1) so the same letter is never shown twice in a row.
    // ------------------------------------------------------------------
    logic [4:0] letter_raw;
    logic [4:0] letter_cand;
    logic [4:0] letter_next;

    // Map the LFSR into a letter that differs from the current target
    always_comb begin
        letter_raw = lfsr_reg[4:0];
        if (letter_raw >= 5'd26) begin
            letter_raw = letter_raw - 5'd26;
        end
        letter_cand = letter_raw + 5'd1;
        letter_next = letter_cand;
        if (letter_cand == target_reg) begin
            letter_next = (letter_cand == 5'd26) ? 5'd1 : letter_cand + 5'd1;
        end
    end

    // ------------------------------------------------------------------
    // Input decode
    // ------------------------------------------------------------------
    logic start_press;
    logic letter_key;
    logic is_hit;
    logic is_miss;
    logic frame_wrap;
    logic round_end;

    assign start_press = key_valid && (key_code == START_CODE);
    assign letter_key  = key_valid && (key_code != 5'd0) && (key_code <= 5'd26);
    assign is_hit      = letter_key && (key_code == target_reg);
    assign is_miss     = letter_key && (key_code != target_reg);
    assign frame_wrap  = frame_tick && (frame_cnt_reg == FC_LAST);
    assign round_end   = frame_wrap && (time_reg == 8'd1);

    // ------------------------------------------------------------------
    // Score increment, saturating at 255. During a streak of three or more
    // earlier hits the award is two points.
    // ------------------------------------------------------------------
    logic [1:0] score_step;
    logic [8:0] score_sum;
    logic [7:0] score_inc;

`ifdef STREAK_BONUS_EN
    assign score_step = (streak_reg >= 3'd3) ? 2'd2 : 2'd1;
`else
    assign score_step = 2'd1;
`endif
    assign score_sum = {1'b0, score_reg} + {7'd0, score_step};
    assign score_inc = score_sum[8] ? 8'hFF : score_sum[7:0];

    // ------------------------------------------------------------------
    // Round sequencer: all state and registered outputs in one process
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            target_reg    <= 5'd0;
            score_reg     <= 8'd0;
            time_reg      <= 8'd0;
            frame_cnt_reg <= '0;
            hit_reg       <= 1'b0;
            miss_reg      <= 1'b0;
            game_over_reg <= 1'b0;
`ifdef STREAK_BONUS_EN
            streak_reg    <= 3'd0;
`endif
        end else begin
            // Pulses last exactly one cycle unless re-armed below
            hit_reg  <= 1'b0;
            miss_reg <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    if (start_press) begin
                        state_reg     <= S_LOAD;
                        game_over_reg <= 1'b0;
                    end
                end

                S_LOAD: begin
                    score_reg     <= 8'd0;
                    time_reg      <= ROUND_LEN;
                    frame_cnt_reg <= '0;
                    target_reg    <= letter_next;
                    state_reg     <= S_PLAY;
                    game_over_reg <= 1'b0;
`ifdef STREAK_BONUS_EN
                    streak_reg    <= 3'd0;
`endif
                end

                S_PLAY: begin
                    if (is_hit) begin
                        hit_reg   <= 1'b1;
                        score_reg <= score_inc;
`ifdef STREAK_BONUS_EN
                        if (streak_reg != 3'd7) begin
                            streak_reg <= streak_reg + 3'd1;
                        end
`endif
                    end else if (is_miss) begin
                        miss_reg <= 1'b1;
`ifdef STREAK_BONUS_EN
                        streak_reg <= 3'd0;
`endif
                    end

                    if (frame_tick) begin
                        if (frame_wrap) begin
                            frame_cnt_reg <= '0;
                            if (time_reg == 8'd1) begin
                                time_reg      <= 8'd0;
                                state_reg     <= S_OVER;
                                game_over_reg <= 1'b1;
                            end else begin
                                time_reg <= time_reg - 8'd1;
                            end
                        end else begin
                            frame_cnt_reg <= frame_cnt_reg + 1'b1;
                        end
                    end

                    // A hit on the final tick still scores, but no new letter appears
                    if (round_end) begin
                        target_reg <= 5'd0;
                    end else if (is_hit) begin
                        target_reg <= letter_next;
                    end
                end

                S_OVER: begin
                    if (start_press) begin
                        state_reg     <= S_LOAD;
                        game_over_reg <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign target_code = target_reg;
    assign score       = score_reg;
    assign time_left   = time_reg;
    assign game_state  = state_reg;
    assign hit         = hit_reg;
    assign miss        = miss_reg;
    assign game_over   = game_over_reg;
`ifdef STREAK_BONUS_EN
    assign streak      = streak_reg;
`endif

endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: self-checking bench for game_controller.
// A reference model predicts the outputs for every driven cycle; the expected
// record is queued when the inputs are driven and compared one edge later.
module tb_game_controller;

    localparam int FPS  = 60;
    localparam int RSEC = 60;

    logic       pclk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] key_code = 5'd0;
    logic       key_valid = 1'b0;
    logic       frame_tick = 1'b0;
    logic [4:0] target_code;
    logic [7:0] score;
    logic [7:0] time_left;
    logic [1:0] game_state;
    logic       hit;
    logic       miss;
    logic       game_over;
`ifdef STREAK_BONUS_EN
    logic [2:0] streak;
`endif

    always #5 pclk = ~pclk;

    game_controller #(
        .FRAMES_PER_SEC (FPS),
        .ROUND_SECONDS  (RSEC),
        .START_CODE     (5'd27),
        .LFSR_SEED      (8'hA5)
    ) dut (
        .pclk        (pclk),
        .reset       (reset),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .frame_tick  (frame_tick),
        .target_code (target_code),
        .score       (score),
        .time_left   (time_left),
        .game_state  (game_state),
        .hit         (hit),
        .miss        (miss),
        .game_over   (game_over)
`ifdef STREAK_BONUS_EN
        ,
        .streak      (streak)
`endif
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_lfsr;
    always @(posedge pclk or posedge reset) begin
        if (reset) m_lfsr <= 8'hA5;
        else       m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end

    int m_state, m_tgt, m_score, m_time, m_fc, m_streak, m_hit, m_miss;

    task automatic model_reset();
        m_state = 0; m_tgt = 0; m_score = 0; m_time = 0;
        m_fc = 0; m_streak = 0; m_hit = 0; m_miss = 0;
    endtask

    function automatic int pick(input logic [7:0] l, input int cur);
        int v;
        v = int'(l[4:0]);
        if (v >= 26) v = v - 26;
        v = v + 1;
        if (v == cur) v = (v == 26) ? 1 : v + 1;
        return v;
    endfunction

    task automatic model_cycle(input logic v, input logic [4:0] c, input logic t);
        int nt;
        int add;
        m_hit = 0;
        m_miss = 0;
        case (m_state)
            0: if (v && c == 5'd27) m_state = 1;
            1: begin
                m_score = 0; m_time = RSEC; m_fc = 0; m_streak = 0;
                m_tgt = pick(m_lfsr, m_tgt);
                m_state = 2;
            end
            2: begin
                nt = m_tgt;
                if (v && c >= 5'd1 && c <= 5'd26) begin
                    if (int'(c) == m_tgt) begin
                        m_hit = 1;
                        add = 1;
`ifdef STREAK_BONUS_EN
                        if (m_streak >= 3) add = 2;
`endif
                        if (m_streak < 7) m_streak++;
                        m_score = (m_score + add > 255) ? 255 : m_score + add;
                        nt = pick(m_lfsr, m_tgt);
                    end else begin
                        m_miss = 1;
                        m_streak = 0;
                    end
                end
                if (t) begin
                    if (m_fc == FPS - 1) begin
                        m_fc = 0;
                        if (m_time == 1) begin
                            m_time = 0; m_state = 3; nt = 0;
                        end else begin
                            m_time--;
                        end
                    end else begin
                        m_fc++;
                    end
                end
                m_tgt = nt;
            end
            default: if (v && c == 5'd27) m_state = 1;
        endcase
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [1:0] st;
        logic [4:0] tgt;
        logic [7:0] sc;
        logic [7:0] tl;
        logic       h;
        logic       m;
        logic       go;
        logic [2:0] sk;
    } exp_t;

    exp_t sb_q[$];

    // One cycle: drive at a falling edge, compare at the next falling edge
    task automatic step(input logic v, input logic [4:0] c, input logic t);
        exp_t e;
        key_valid  = v;
        key_code   = c;
        frame_tick = t;
        model_cycle(v, c, t);
        e.st  = 2'(m_state);
        e.tgt = 5'(m_tgt);
        e.sc  = 8'(m_score);
        e.tl  = 8'(m_time);
        e.h   = (m_hit != 0);
        e.m   = (m_miss != 0);
        e.go  = (m_state == 3);
        e.sk  = 3'(m_streak);
        sb_q.push_back(e);
        @(negedge pclk);
        key_valid  = 1'b0;
        key_code   = 5'd0;
        frame_tick = 1'b0;
        e = sb_q.pop_front();
        check_val("state", int'(game_state), int'(e.st));
        check_val("target", int'(target_code), int'(e.tgt));
        check_val("score", int'(score), int'(e.sc));
        check_val("time_left", int'(time_left), int'(e.tl));
        check_val("hit", int'(hit), int'(e.h));
        check_val("miss", int'(miss), int'(e.m));
        check_val("game_over", int'(game_over), int'(e.go));
        check_val("no_hit_and_miss", int'(hit & miss), 0);
`ifdef STREAK_BONUS_EN
        check_val("streak", int'(streak), int'(e.sk));
`endif
        if (v) $display("key code=%0d tick=%0d -> state=%0d hit=%0d miss=%0d score=%0d target=%0d",
                        c, t, game_state, hit, miss, score, target_code);
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_state"}, int'(game_state), 0);
        check_val({tag, "_target"}, int'(target_code), 0);
        check_val({tag, "_score"}, int'(score), 0);
        check_val({tag, "_time"}, int'(time_left), 0);
        check_val({tag, "_hit"}, int'(hit), 0);
        check_val({tag, "_miss"}, int'(miss), 0);
        check_val({tag, "_over"}, int'(game_over), 0);
`ifdef STREAK_BONUS_EN
        check_val({tag, "_streak"}, int'(streak), 0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int prev_tgt;
        int exp_sc[5];
        model_reset();

        // Reset state
        @(negedge pclk);
        @(negedge pclk);
        check_reset_vals("reset");
        reset = 1'b0;

        // IDLE ignores ticks and non-start keys
        for (int i = 0; i < 100; i++)
            step((i == 20) || (i == 40), (i == 20) ? 5'd3 : 5'd30, (i % 10) == 5);
        check_val("idle_state", int'(game_state), 0);

        // Start -> LOAD -> PLAY
        step(1'b1, 5'd27, 1'b0);
        check_val("load_state", int'(game_state), 1);
        step(1'b0, 5'd0, 1'b0);
        check_val("play_state", int'(game_state), 2);
        check_val("play_time", int'(time_left), RSEC);
        check_val("tgt_range", int'(target_code >= 5'd1 && target_code <= 5'd26), 1);

        // Ten correct keys, each new letter differs from the previous one
        for (int i = 0; i < 10; i++) begin
            prev_tgt = m_tgt;
            step(1'b1, 5'(m_tgt), 1'b0);
            check_val("tgt_new", int'(int'(target_code) != prev_tgt), 1);
        end
`ifndef STREAK_BONUS_EN
        check_val("score10", int'(score), 10);
`endif
        // One wrong letter, then ignored codes (none, start, out of range)
        prev_tgt = m_tgt;
        step(1'b1, (m_tgt == 1) ? 5'd2 : 5'd1, 1'b0);
        check_val("miss_pulse", int'(miss), 1);
        check_val("miss_tgt_hold", int'(target_code), prev_tgt);
        step(1'b1, 5'd0, 1'b0);
        step(1'b1, 5'd27, 1'b0);
        step(1'b1, 5'd30, 1'b0);

        // Countdown to zero; final tick coincides with a correct key
        for (int i = 1; i < FPS * RSEC; i++) begin
            step(1'b0, 5'd0, 1'b1);
            step(1'b0, 5'd0, 1'b0);
        end
        check_val("time_before_end", int'(time_left), 1);
        step(1'b1, 5'(m_tgt), 1'b1);
        check_val("end_state", int'(game_state), 3);
        check_val("end_over", int'(game_over), 1);
        check_val("end_target", int'(target_code), 0);
        check_val("end_hit", int'(hit), 1);

        // OVER ignores letters and ticks, start begins a new round
        step(1'b1, 5'd4, 1'b0);
        step(1'b0, 5'd0, 1'b1);
        step(1'b1, 5'd27, 1'b0);
        step(1'b0, 5'd0, 1'b0);
        check_val("restart_score", int'(score), 0);

        // Score saturation
        for (int i = 0; i < 260; i++) step(1'b1, 5'(m_tgt), 1'b0);
        check_val("sat_score", int'(score), 255);
        check_val("sat_hit", int'(hit), 1);

        // Asynchronous reset mid-round
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async_reset");
        model_reset();
        @(negedge pclk);
        reset = 1'b0;
        step(1'b1, 5'd5, 1'b0);

        // New round; with the bonus build, check the streak scoring sequence
        step(1'b1, 5'd27, 1'b0);
        step(1'b0, 5'd0, 1'b0);
`ifdef STREAK_BONUS_EN
        exp_sc = '{1, 2, 3, 5, 7};
`else
        exp_sc = '{1, 2, 3, 4, 5};
`endif
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 5'(m_tgt), 1'b0);
            check_val("run_score", int'(score), exp_sc[i]);
        end
        step(1'b1, (m_tgt == 1) ? 5'd2 : 5'd1, 1'b0);
        step(1'b1, 5'(m_tgt), 1'b0);
`ifdef STREAK_BONUS_EN
        check_val("after_miss_score", int'(score), 8);
        check_val("after_miss_streak", int'(streak), 1);
`else
        check_val("after_miss_score", int'(score), 6);
`endif

        // Reset again while playing
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("reset_play");
        model_reset();
        @(negedge pclk);
        reset = 1'b0;
        step(1'b0, 5'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
